// File: rtl/addsub_response_checker.sv
// Purpose : response monitor for the WIDTH-bit adder/subtractor; recomputes each result,
//           counts passes/fails, captures the first failing vector, flags run completion.
// Latency : 1 cycle from accepted tuple to check_valid/check_ok; no backpressure, one tuple per cycle.
//
// Ports:
//   clk, rst, clear          - clock, synchronous active-high reset, synchronous restart (same effect)
//   in_valid, a, b, subtract - observed stimulus tuple
//   result, cout             - observed response of the adder/subtractor
//   check_valid, check_ok    - one-cycle check pulse and its outcome
//   pass_count, fail_count   - saturating outcome counters
//   error, overrun           - sticky failure / input-after-done flags
//   done, all_pass           - run complete, and complete without failures
//   ff_a, ff_b, ff_sub, ff_result, ff_cout - first failing vector
module addsub_response_checker #(
    parameter int WIDTH       = 4,
    parameter int CNT_W       = 8,
    parameter int NUM_VECTORS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    input  logic [WIDTH-1:0] result,
    input  logic             cout,
    output logic             check_valid,
    output logic             check_ok,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             error,
    output logic             overrun,
    output logic             done,
    output logic             all_pass,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic             ff_sub,
    output logic [WIDTH-1:0] ff_result,
    output logic             ff_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   TARGET  = (CNT_W+1)'(NUM_VECTORS);

    state_t state;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   exp_sum;
    logic             vec_ok;
    logic             accept;
    logic [CNT_W-1:0] pass_nxt;
    logic [CNT_W-1:0] fail_nxt;
    logic [CNT_W:0]   total_nxt;
    logic             run_end;

    // Subtraction is a + ~b + 1, so the carry-out reads as "no borrow".
    always_comb begin
        b_eff   = subtract ? ~b : b;
        exp_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract};
        vec_ok  = (result == exp_sum[WIDTH-1:0]) && (cout == exp_sum[WIDTH]);
    end

    // Reset is handled in the sequential block, where it overrides everything.
    assign accept = in_valid && (state != DONE);

    // Post-increment counts; saturate rather than wrap if NUM_VECTORS is oversized.
    always_comb begin
        pass_nxt = pass_count;
        fail_nxt = fail_count;
        if (accept) begin
            if (vec_ok) begin
                if (pass_count != CNT_MAX) pass_nxt = pass_count + 1'b1;
            end else begin
                if (fail_count != CNT_MAX) fail_nxt = fail_count + 1'b1;
            end
        end
        total_nxt = {1'b0, pass_nxt} + {1'b0, fail_nxt};
        run_end   = accept && (total_nxt == TARGET);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= IDLE;
            check_valid <= 1'b0;
            check_ok    <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
            error       <= 1'b0;
            overrun     <= 1'b0;
            done        <= 1'b0;
            all_pass    <= 1'b0;
            ff_a        <= '0;
            ff_b        <= '0;
            ff_sub      <= 1'b0;
            ff_result   <= '0;
            ff_cout     <= 1'b0;
        end else begin
            check_valid <= accept;
            check_ok    <= accept && vec_ok;
            pass_count  <= pass_nxt;
            fail_count  <= fail_nxt;

            // First failure only: error doubles as the "already captured" flag.
            if (accept && !vec_ok && !error) begin
                error     <= 1'b1;
                ff_a      <= a;
                ff_b      <= b;
                ff_sub    <= subtract;
                ff_result <= result;
                ff_cout   <= cout;
            end

            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        if (run_end) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            all_pass <= (fail_nxt == '0);
                        end else begin
                            state    <= RUN;
                        end
                    end
                end
                DONE: begin
                    if (in_valid) overrun <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_response_checker.sv
module tb_addsub_response_checker;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, subtract, cout;
    logic [3:0] a, b, result;
    logic       check_valid, check_ok, error, overrun, done, all_pass, ff_sub, ff_cout;
    logic [7:0] pass_count, fail_count;
    logic [3:0] ff_a, ff_b, ff_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    addsub_response_checker #(.WIDTH(4), .CNT_W(8), .NUM_VECTORS(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .a(a), .b(b), .subtract(subtract), .result(result), .cout(cout),
        .check_valid(check_valid), .check_ok(check_ok),
        .pass_count(pass_count), .fail_count(fail_count),
        .error(error), .overrun(overrun), .done(done), .all_pass(all_pass),
        .ff_a(ff_a), .ff_b(ff_b), .ff_sub(ff_sub), .ff_result(ff_result), .ff_cout(ff_cout)
    );

    // Drive a tuple (inputs change #1 after an edge), then advance one edge and settle.
    task automatic step(input logic v, input logic [3:0] ta, input logic [3:0] tb,
                        input logic ts, input logic [3:0] tr, input logic tc);
        in_valid = v; a = ta; b = tb; subtract = ts; result = tr; cout = tc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0;
        step(1'b1, 4'd5, 4'd3, 1'b1, 4'd2, 1'b1);   // discarded by reset
        rst = 1'b0;
        checks++; if (check_valid !== 1'b0) begin errors++; $display("FAIL reset_check_valid: got %0b want 0", check_valid); end
        checks++; if (pass_count !== 8'd0) begin errors++; $display("FAIL reset_pass_count: got %0d want 0", pass_count); end
        checks++; if (fail_count !== 8'd0) begin errors++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
        checks++; if ({error, overrun, done, all_pass} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {error, overrun, done, all_pass}); end
        checks++; if ({ff_a, ff_b, ff_sub, ff_result, ff_cout} !== 14'd0) begin errors++; $display("FAIL reset_ff: got %h want 0", {ff_a, ff_b, ff_sub, ff_result, ff_cout}); end
    endtask

    task automatic test_pass_sequence();
        logic [3:0] va [4] = '{4'd0, 4'd1, 4'd5, 4'd14};
        logic [3:0] vb [4] = '{4'd0, 4'd1, 4'd3, 4'd12};
        logic       vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] vr [4] = '{4'd0, 4'd0, 4'd2, 4'd10};
        logic       vc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, va[i], vb[i], vs[i], vr[i], vc[i]);
            checks++; if ({check_valid, check_ok} !== 2'b11) begin errors++; $display("FAIL seq_check_%0d: got v=%0b ok=%0b want 1 1", i, check_valid, check_ok); end
            checks++; if (done !== (i == 3)) begin errors++; $display("FAIL seq_done_%0d: got %0b want %0b", i, done, (i == 3)); end
        end
        checks++; if (pass_count !== 8'd4) begin errors++; $display("FAIL seq_pass_count: got %0d want 4", pass_count); end
        checks++; if (fail_count !== 8'd0) begin errors++; $display("FAIL seq_fail_count: got %0d want 0", fail_count); end
        checks++; if (all_pass !== 1'b1) begin errors++; $display("FAIL seq_all_pass: got %0b want 1", all_pass); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL seq_error: got %0b want 0", error); end
        step(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++; if (check_valid !== 1'b0) begin errors++; $display("FAIL seq_pulse_width: got %0b want 0", check_valid); end
    endtask

    // Runs straight after test_pass_sequence, while the FSM sits in DONE.
    task automatic test_overrun();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %0b want 0", overrun); end
        step(1'b1, 4'd2, 4'd2, 1'b0, 4'd4, 1'b0);
        checks++; if (check_valid !== 1'b0) begin errors++; $display("FAIL ovr_check_valid: got %0b want 0", check_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0b want 1", overrun); end
        checks++; if (pass_count !== 8'd4) begin errors++; $display("FAIL ovr_pass_count: got %0d want 4", pass_count); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovr_done: got %0b want 1", done); end
        step(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
    endtask

    task automatic test_borrow();
        do_reset();
        step(1'b1, 4'd3, 4'd5, 1'b1, 4'd14, 1'b0);
        checks++; if ({check_valid, check_ok} !== 2'b11) begin errors++; $display("FAIL borrow_pass: got v=%0b ok=%0b want 1 1", check_valid, check_ok); end
        step(1'b1, 4'd3, 4'd5, 1'b1, 4'd14, 1'b1);
        checks++; if ({check_valid, check_ok} !== 2'b10) begin errors++; $display("FAIL borrow_bad_cout: got v=%0b ok=%0b want 1 0", check_valid, check_ok); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL borrow_error: got %0b want 1", error); end
        checks++; if (ff_cout !== 1'b1) begin errors++; $display("FAIL borrow_ff_cout: got %0b want 1", ff_cout); end
        checks++; if (ff_result !== 4'd14) begin errors++; $display("FAIL borrow_ff_result: got %0d want 14", ff_result); end
        checks++; if ({pass_count, fail_count} !== {8'd1, 8'd1}) begin errors++; $display("FAIL borrow_counts: got p=%0d f=%0d want 1 1", pass_count, fail_count); end
    endtask

    task automatic test_inject();
        do_reset();
        step(1'b1, 4'd5, 4'd3, 1'b1, 4'd3, 1'b1);
        checks++; if ({check_ok, error, fail_count} !== {1'b0, 1'b1, 8'd1}) begin errors++; $display("FAIL inj_first: got ok=%0b err=%0b f=%0d want 0 1 1", check_ok, error, fail_count); end
        step(1'b1, 4'd0, 4'd0, 1'b0, 4'd1, 1'b0);
        checks++; if (fail_count !== 8'd2) begin errors++; $display("FAIL inj_fail_count: got %0d want 2", fail_count); end
        checks++; if ({ff_a, ff_b, ff_sub, ff_result, ff_cout} !== {4'd5, 4'd3, 1'b1, 4'd3, 1'b1}) begin errors++; $display("FAIL inj_ff: got a=%0d b=%0d s=%0b r=%0d c=%0b want 5 3 1 3 1", ff_a, ff_b, ff_sub, ff_result, ff_cout); end
        step(1'b1, 4'd7, 4'd8, 1'b0, 4'd15, 1'b0);
        step(1'b1, 4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
        checks++; if ({done, all_pass} !== 2'b10) begin errors++; $display("FAIL inj_done: got done=%0b all_pass=%0b want 1 0", done, all_pass); end
        checks++; if (pass_count !== 8'd2) begin errors++; $display("FAIL inj_pass_count: got %0d want 2", pass_count); end
    endtask

    task automatic test_clear_mid_run();
        do_reset();
        step(1'b1, 4'd1, 4'd2, 1'b0, 4'd3, 1'b0);
        step(1'b1, 4'd4, 4'd4, 1'b0, 4'd0, 1'b0);   // deliberate failure
        clear = 1'b1;
        step(1'b1, 4'd2, 4'd2, 1'b0, 4'd4, 1'b0);
        clear = 1'b0;
        checks++; if (check_valid !== 1'b0) begin errors++; $display("FAIL clr_check_valid: got %0b want 0", check_valid); end
        checks++; if ({pass_count, fail_count} !== 16'd0) begin errors++; $display("FAIL clr_counts: got p=%0d f=%0d want 0 0", pass_count, fail_count); end
        checks++; if ({done, error} !== 2'b00) begin errors++; $display("FAIL clr_flags: got done=%0b err=%0b want 0 0", done, error); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'd9, 4'd4, 1'b1, 4'd5, 1'b1);
            checks++; if (done !== (i == 3)) begin errors++; $display("FAIL clr_rerun_done_%0d: got %0b want %0b", i, done, (i == 3)); end
        end
        checks++; if ({pass_count, all_pass} !== {8'd4, 1'b1}) begin errors++; $display("FAIL clr_rerun_final: got p=%0d all=%0b want 4 1", pass_count, all_pass); end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'(i), 4'd6, 1'b0, 4'(i + 6), 1'b0);
            checks++; if ({check_valid, check_ok} !== 2'b11) begin errors++; $display("FAIL gap_valid_%0d: got v=%0b ok=%0b want 1 1", i, check_valid, check_ok); end
            step(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
            checks++; if (check_valid !== 1'b0) begin errors++; $display("FAIL gap_idle_%0d: got %0b want 0", i, check_valid); end
        end
        checks++; if ({pass_count, fail_count, done, all_pass} !== {8'd4, 8'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL gap_final: got p=%0d f=%0d done=%0b all=%0b want 4 0 1 1", pass_count, fail_count, done, all_pass); end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; subtract = 1'b0; result = '0; cout = 1'b0;
        #1;
        test_reset();
        test_pass_sequence();
        test_overrun();
        test_borrow();
        test_inject();
        test_clear_mid_run();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
